// File: rtl/core_pkg.sv
// Shared core types: load/store operation encoding driven by the control unit.
package core_pkg;

    typedef enum logic [3:0] {
        LSU_NONE_OP = 4'd0,
        LSU_LB      = 4'd1,
        LSU_LH      = 4'd2,
        LSU_LW      = 4'd3,
        LSU_LBU     = 4'd4,
        LSU_LHU     = 4'd5,
        LSU_SB      = 4'd6,
        LSU_SH      = 4'd7,
        LSU_SW      = 4'd8
    } lsu_op_t;

endpackage

// File: rtl/lsu.sv
// Load/store unit: one data-bus transaction per accepted op, store alignment and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word ops complete with lsu_err instead of a bus access.
module lsu
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  lsu_op_t           lsu_op,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_rvalid,
    output logic              lsu_err,
    output logic              data_req,
    input  logic              data_gnt,
    output logic              data_we,
    output logic [3:0]        data_be,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_rvalid,
    input  logic [31:0]       data_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]        state;
    lsu_op_t           op_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [31:0]       wdata_q;

    logic [1:0]  k;
    logic        op_valid;
    logic        op_store;
    logic [1:0]  op_size;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        misalign;

    assign k = lsu_addr[1:0];

    always_comb begin
        op_valid = 1'b1;
        op_store = 1'b0;
        op_size  = 2'd0;
        case (lsu_op)
            LSU_LB, LSU_LBU: op_size = 2'd0;
            LSU_LH, LSU_LHU: op_size = 2'd1;
            LSU_LW:          op_size = 2'd2;
            LSU_SB: begin op_size = 2'd0; op_store = 1'b1; end
            LSU_SH: begin op_size = 2'd1; op_store = 1'b1; end
            LSU_SW: begin op_size = 2'd2; op_store = 1'b1; end
            default:         op_valid = 1'b0;
        endcase

        case (op_size)
            2'd0: begin
                req_be    = 4'b0001 << k;
                req_wdata = {4{lsu_wdata[7:0]}};
            end
            2'd1: begin
                req_be    = 4'b0011 << {k[1], 1'b0};
                req_wdata = {2{lsu_wdata[15:0]}};
            end
            default: begin
                req_be    = 4'hF;
                req_wdata = lsu_wdata;
            end
        endcase

        misalign = ((op_size == 2'd1) && k[0]) || ((op_size == 2'd2) && (k != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= LSU_NONE_OP;
            k_q     <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q <= lsu_op;
                        k_q  <= k;
`ifdef LSU_MISALIGN_TRAP_EN
                        // Trapped ops leave the bus registers untouched; no request is made.
                        if (misalign) begin
                            state <= S_ERR;
                        end else
`endif
                        begin
                            addr_q  <= {lsu_addr[ADDR_W-1:2], 2'b00};
                            be_q    <= req_be;
                            we_q    <= op_store;
                            wdata_q <= op_store ? req_wdata : '0;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ:   if (data_gnt) state <= S_WAIT;
                S_WAIT:  if (data_rvalid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign data_req   = (state == S_REQ);
    assign data_we    = we_q;
    assign data_be    = be_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

    logic        resp;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    assign resp = (state == S_WAIT) && data_rvalid;

    always_comb begin
        case (k_q)
            2'd0:    rd_byte = data_rdata[7:0];
            2'd1:    rd_byte = data_rdata[15:8];
            2'd2:    rd_byte = data_rdata[23:16];
            default: rd_byte = data_rdata[31:24];
        endcase
        rd_half = k_q[1] ? data_rdata[31:16] : data_rdata[15:0];

        case (op_q)
            LSU_LB:  load_val = {{24{rd_byte[7]}}, rd_byte};
            LSU_LBU: load_val = {24'd0, rd_byte};
            LSU_LH:  load_val = {{16{rd_half[15]}}, rd_half};
            LSU_LHU: load_val = {16'd0, rd_half};
            LSU_LW:  load_val = data_rdata;
            default: load_val = '0;
        endcase
    end

    assign lsu_rdata = resp ? load_val : '0;

`ifdef LSU_MISALIGN_TRAP_EN
    assign lsu_rvalid = resp || (state == S_ERR);
    assign lsu_err    = (state == S_ERR);
`else
    assign lsu_rvalid = resp;
    assign lsu_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized ops against an arithmetic model.
module tb_lsu;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    lsu_op_t     lsu_op;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        lsu_rvalid, lsu_err;
    logic        data_req, data_gnt, data_we, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;

    int total = 0;
    int bad   = 0;

    // observations of the most recent transaction
    int          obs_req, obs_rv, obs_lat;
    bit          obs_timeout;
    logic [31:0] obs_addr, obs_wd, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_err;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_err(lsu_err),
        .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we),
        .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata)
    );

    function automatic int unsigned m_size(lsu_op_t op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return 1;
            LSU_LH, LSU_LHU, LSU_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit m_store(lsu_op_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic bit m_trap(lsu_op_t op, logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % m_size(op)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned m_off(lsu_op_t op, logic [31:0] addr);
        int unsigned off = addr % 4;
        return off - (off % m_size(op));
    endfunction

    function automatic logic [3:0] m_be(lsu_op_t op, logic [31:0] addr);
        int unsigned v = ((1 << m_size(op)) - 1) << m_off(op, addr);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(lsu_op_t op, logic [31:0] wd);
        if (!m_store(op)) return 32'd0;
        if (m_size(op) == 1) return (wd % 256) * 32'h0101_0101;
        if (m_size(op) == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(lsu_op_t op, logic [31:0] addr, logic [31:0] mem);
        longint unsigned v, span;
        int unsigned n = m_size(op);
        if (m_store(op) || m_trap(op, addr)) return 32'd0;
        span = 64'd1 << (8 * n);
        v = (longint'(mem) >> (8 * m_off(op, addr))) % span;
        if (((op == LSU_LB) || (op == LSU_LH)) && (v >= span / 2))
            v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // Drives one op and acts as the bus (grant/response delays); fills obs_*.
    task automatic run_op(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mem, input int gnt_dly, input int rv_dly,
                          input bit noise, input bit chain);
        int gcnt = 0;
        int rcnt = 0;
        bit granted = 0;
        bit done = 0;
        obs_req = 0; obs_rv = 0; obs_lat = -1; obs_timeout = 0;
        obs_addr = 'x; obs_wd = 'x; obs_be = 'x; obs_we = 'x; obs_rdata = 'x; obs_err = 'x;
        @(posedge clk); #1;
        lsu_op = op; lsu_addr = addr; lsu_wdata = wdata;
        data_gnt = 1'b0; data_rvalid = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk); #1;
            data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = $urandom;
            if (data_req) begin
                obs_req++;
                obs_addr = data_addr; obs_be = data_be; obs_we = data_we; obs_wd = data_wdata;
                if (gcnt == gnt_dly) begin data_gnt = 1'b1; granted = 1; end
                else gcnt++;
                if (noise) data_rvalid = 1'($urandom_range(0, 1));
            end else if (granted) begin
                if (rcnt == rv_dly) begin data_rvalid = 1'b1; data_rdata = mem; end
                else rcnt++;
            end
            #1;
            if (lsu_rvalid) begin
                obs_rv++; obs_lat = cyc; obs_rdata = lsu_rdata; obs_err = lsu_err; done = 1;
            end
        end
        if (!done) obs_timeout = 1;
        if (!chain) begin
            @(posedge clk); #1;
            lsu_op = LSU_NONE_OP; data_gnt = 1'b0; data_rvalid = 1'b0;
            #1;
            if (lsu_rvalid) obs_rv++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lsu_op = LSU_NONE_OP; lsu_addr = '0; lsu_wdata = '0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({data_req, data_we, data_be} !== 6'd0) begin
            bad++; $display("FAIL reset_ctrl got req/we/be=%b want 000000", {data_req, data_we, data_be});
        end
        total++;
        if ({data_addr, data_wdata} !== 64'd0) begin
            bad++; $display("FAIL reset_bus got addr=%h wdata=%h want 0", data_addr, data_wdata);
        end
        total++;
        if ({lsu_rvalid, lsu_err, lsu_rdata} !== 34'd0) begin
            bad++; $display("FAIL reset_lsu got rvalid=%b err=%b rdata=%h want 0", lsu_rvalid, lsu_err, lsu_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lb();
        run_op(LSU_LB, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, 0);
        total++;
        if (obs_be !== 4'b1000) begin bad++; $display("FAIL lb_be got %b want 1000", obs_be); end
        total++;
        if (obs_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got %h want ffffff80", obs_rdata); end
        total++;
        if (obs_lat !== 2) begin bad++; $display("FAIL lb_latency got %0d want 2", obs_lat); end
        total++;
        if ({obs_we, obs_addr} !== {1'b0, 32'h100}) begin
            bad++; $display("FAIL lb_bus got we=%b addr=%h want we=0 addr=100", obs_we, obs_addr);
        end
    endtask

    task automatic test_sh();
        run_op(LSU_SH, 32'h202, 32'hDEAD_BEEF, 32'h1111_2222, 0, 0, 0, 0);
        total++;
        if (obs_addr !== 32'h200) begin bad++; $display("FAIL sh_addr got %h want 200", obs_addr); end
        total++;
        if (obs_be !== 4'b1100) begin bad++; $display("FAIL sh_be got %b want 1100", obs_be); end
        total++;
        if (obs_wd !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata got %h want beefbeef", obs_wd); end
        total++;
        if ({obs_we, obs_rdata} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL sh_we_rdata got we=%b rdata=%h want we=1 rdata=0", obs_we, obs_rdata);
        end
    endtask

    task automatic test_delayed_lw();
        run_op(LSU_LW, 32'h40, 32'h0, 32'hCAFE_F00D, 3, 2, 0, 0);
        total++;
        if (obs_req !== 4) begin bad++; $display("FAIL lw_req_hold got %0d want 4", obs_req); end
        total++;
        if (obs_rv !== 1) begin bad++; $display("FAIL lw_rvalid_pulses got %0d want 1", obs_rv); end
        total++;
        if (obs_lat !== 7) begin bad++; $display("FAIL lw_latency got %0d want 7", obs_lat); end
        total++;
        if (obs_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL lw_rdata got %h want cafef00d", obs_rdata); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        lsu_op = LSU_SW; lsu_addr = 32'h304; lsu_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        data_gnt = 1'b1;
        @(posedge clk); #1;
        data_gnt = 1'b0;
        rst_n = 1'b0; lsu_op = LSU_NONE_OP;
        #1;
        total++;
        if ({data_req, data_we, data_be, data_addr, data_wdata, lsu_rvalid, lsu_err, lsu_rdata} !== '0) begin
            bad++; $display("FAIL midreset_outputs got req=%b we=%b be=%b addr=%h wd=%h rv=%b err=%b rd=%h want 0",
                            data_req, data_we, data_be, data_addr, data_wdata, lsu_rvalid, lsu_err, lsu_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h1234_5678;
        #1;
        total++;
        if ({lsu_rvalid, lsu_rdata} !== 33'd0) begin
            bad++; $display("FAIL midreset_late_resp got rvalid=%b rdata=%h want 0", lsu_rvalid, lsu_rdata);
        end
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        total++;
        if ({data_req, lsu_rvalid} !== 2'b00) begin
            bad++; $display("FAIL midreset_idle got req=%b rvalid=%b want 00", data_req, lsu_rvalid);
        end
    endtask

    task automatic test_misalign();
        run_op(LSU_LW, 32'h101, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        total++;
        if (obs_req !== 0) begin bad++; $display("FAIL misalign_noreq got %0d want 0", obs_req); end
        total++;
        if ({obs_lat, obs_err, obs_rdata} !== {32'd1, 1'b1, 32'd0}) begin
            bad++; $display("FAIL misalign_trap got lat=%0d err=%b rdata=%h want 1 1 0", obs_lat, obs_err, obs_rdata);
        end
`else
        total++;
        if ({obs_addr, obs_be} !== {32'h100, 4'hF}) begin
            bad++; $display("FAIL misalign_issue got addr=%h be=%b want 100 1111", obs_addr, obs_be);
        end
        total++;
        if ({obs_err, obs_rdata} !== {1'b0, 32'h0BAD_CAFE}) begin
            bad++; $display("FAIL misalign_data got err=%b rdata=%h want 0 0badcafe", obs_err, obs_rdata);
        end
`endif
    endtask

    task automatic test_back_to_back();
        run_op(LSU_LHU, 32'h2, 32'h0, 32'h8765_4321, 0, 0, 0, 1);
        total++;
        if (obs_rdata !== 32'h0000_8765) begin bad++; $display("FAIL b2b_lhu got %h want 00008765", obs_rdata); end
        run_op(LSU_SW, 32'h48, 32'h0123_4567, 32'h0, 0, 0, 0, 0);
        total++;
        if (obs_lat !== 2) begin bad++; $display("FAIL b2b_sw_latency got %0d want 2", obs_lat); end
        total++;
        if ({obs_we, obs_be, obs_wd, obs_addr} !== {1'b1, 4'hF, 32'h0123_4567, 32'h48}) begin
            bad++; $display("FAIL b2b_sw_bus got we=%b be=%b wd=%h addr=%h", obs_we, obs_be, obs_wd, obs_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            lsu_op_t     op    = lsu_op_t'($urandom_range(1, 8));
            logic [31:0] addr  = $urandom;
            logic [31:0] wd    = $urandom;
            logic [31:0] mem   = $urandom;
            int          g     = $urandom_range(0, 3);
            int          r     = $urandom_range(0, 3);
            bit          chain = (i != 39) && ($urandom_range(0, 1) == 1);
            bit          trap  = m_trap(op, addr);
            run_op(op, addr, wd, mem, g, r, 1, chain);
            total++;
            if (obs_timeout || obs_rv !== 1) begin
                bad++; $display("FAIL rnd%0d_done got timeout=%0d pulses=%0d want 0 1", i, obs_timeout, obs_rv);
            end
            total++;
            if (obs_lat !== (trap ? 1 : g + r + 2)) begin
                bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, obs_lat, trap ? 1 : g + r + 2);
            end
            total++;
            if ({obs_rdata, obs_err} !== {m_rdata(op, addr, mem), trap}) begin
                bad++; $display("FAIL rnd%0d_result op=%s addr=%h got rdata=%h err=%b want %h %b", i, op.name(),
                                addr, obs_rdata, obs_err, m_rdata(op, addr, mem), trap);
            end
            if (!trap) begin
                total++;
                if ({obs_req, obs_addr, obs_be, obs_we, obs_wd} !==
                    {g + 1, addr & 32'hFFFF_FFFC, m_be(op, addr), m_store(op), m_wdata(op, wd)}) begin
                    bad++; $display("FAIL rnd%0d_bus op=%s addr=%h got req=%0d a=%h be=%b we=%b wd=%h want %0d %h %b %b %h",
                                    i, op.name(), addr, obs_req, obs_addr, obs_be, obs_we, obs_wd,
                                    g + 1, addr & 32'hFFFF_FFFC, m_be(op, addr), m_store(op), m_wdata(op, wd));
                end
            end else begin
                total++;
                if (obs_req !== 0) begin bad++; $display("FAIL rnd%0d_trap_req got %0d want 0", i, obs_req); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_delayed_lw();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
